uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter HEADER, default 8'h55, meaning the frame start byte.
REQ-002 The block SHALL have parameter CMD_WR, default 8'h01, meaning the write command code.
REQ-003 The block SHALL have parameter CMD_RD, default 8'h02, meaning the read command code.
REQ-004 The block SHALL have parameter TIMEOUT, default 52080 (52 when SIM is defined), meaning the inter-byte timeout in clk cycles.
REQ-005 The block SHALL have port clk  in  1  system clock.
REQ-006 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port rx_data  in  8  received byte from the UART receiver.
REQ-008 The block SHALL have port rx_valid  in  1  single-cycle strobe; rx_data is valid in the same cycle.
REQ-009 The block SHALL have port sdram_done  in  1  single-cycle pulse from the SDRAM controller ending the issued burst.
REQ-010 The block SHALL have port wfifo_wr_en  out  1  write strobe into the SDRAM write FIFO.
REQ-011 The block SHALL have port wfifo_wr_data  out  8  payload byte to the write FIFO.
REQ-012 The block SHALL have port wr_trig  out  1  single-cycle pulse that starts an SDRAM write burst.
REQ-013 The block SHALL have port rd_trig  out  1  single-cycle pulse that starts an SDRAM read burst.
REQ-014 The block SHALL have port burst_len  out  8  payload length (1..255), held stable from the LEN byte until return to IDLE.
REQ-015 The block SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 The block SHALL have port err  out  1  single-cycle pulse on frame error.

Function
REQ-017 The frame format SHALL be HEADER, CMD, LEN, then LEN payload bytes for CMD_WR only; a CMD_RD frame SHALL carry no payload.
REQ-018 The FSM SHALL have the states IDLE, CMD, LEN, DATA, ISSUE and WAIT.
REQ-019 IDLE: rx_valid with HEADER SHALL move to CMD; any other byte SHALL be discarded silently.
REQ-020 CMD: CMD_WR or CMD_RD SHALL be latched and the FSM SHALL move to LEN; any other code SHALL pulse err and return to IDLE.
REQ-021 LEN: a nonzero byte SHALL be latched into burst_len; CMD_WR SHALL then go to DATA and CMD_RD to ISSUE; LEN=0 SHALL pulse err and return to IDLE.
REQ-022 DATA: each rx_valid SHALL drive wfifo_wr_en=1 and wfifo_wr_data=rx_data on the next cycle (1-cycle latency), and SHALL increment an 8-bit payload counter.
REQ-023 DATA: the FSM SHALL move to ISSUE once the byte that brings the payload counter to burst_len has been accepted.
REQ-024 ISSUE: the FSM SHALL pulse wr_trig (write) or rd_trig (read) for exactly one cycle, then move to WAIT.
REQ-025 WAIT: sdram_done SHALL return the FSM to IDLE; rx_valid in WAIT SHALL pulse err and drop the byte, with no state change.
REQ-026 Timeout: a counter SHALL clear on every rx_valid and on entry to CMD; in CMD, LEN or DATA, reaching TIMEOUT-1 SHALL pulse err and return to IDLE; any FIFO writes already done SHALL NOT be retracted and no trig SHALL be issued.
REQ-027 If rx_valid and the timeout terminal count occur in the same cycle, the byte SHALL win and the timeout SHALL NOT fire.
REQ-028 sdram_done outside WAIT SHALL be ignored.
REQ-029 A HEADER byte received in CMD, LEN or DATA SHALL be treated as ordinary data; there SHALL be no resync.

Reset
REQ-030 While rst_n=0 the FSM SHALL be in IDLE and all outputs and counters SHALL be 0, including in mid-frame or in WAIT.
REQ-031 After reset release the block SHALL accept a HEADER on the first clk edge.

Structure
REQ-032 Package uart_cmd_pkg SHALL hold the state encoding and the default HEADER/CMD_WR/CMD_RD constants.
REQ-033 The timeout counter SHALL be a sub-module, byte_timer (inputs clr and en, output expire pulse).
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Send 55 01 03 11 22 33, then pulse sdram_done -> three wfifo_wr_en with data 11, 22, 33, then one wr_trig, burst_len=3, busy falls after done.
REQ-036 Send 55 02 10 -> rd_trig once, burst_len=8'h10, no wfifo_wr_en; busy stays high until sdram_done.
REQ-037 Send 55 07, and separately 55 01 00 -> one err pulse each, return to IDLE, no trig.
REQ-038 Send 55 01 04 AA BB, then idle for TIMEOUT cycles -> err pulse, two FIFO writes only; a following 55 02 01 is processed normally.
REQ-039 Byte arrives in WAIT -> err pulse, state unchanged; assert rst_n=0 during DATA -> all outputs 0 immediately, IDLE after release.
REQ-040 Send 00 FF 55 02 01 -> leading garbage ignored, single rd_trig.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command front-end: FSM encoding and default
// frame byte values.
package uart_cmd_pkg;

   localparam logic [7:0] HEADER_DEF = 8'h55;
   localparam logic [7:0] CMD_WR_DEF = 8'h01;
   localparam logic [7:0] CMD_RD_DEF = 8'h02;

`ifdef SIM
   localparam int TIMEOUT_DEF = 52;
`else
   localparam int TIMEOUT_DEF = 52080;
`endif

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CMD   = 3'd1;
   localparam logic [2:0] ST_LEN   = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_ISSUE = 3'd4;
   localparam logic [2:0] ST_WAIT  = 3'd5;

endpackage

// File: rtl/uart_cmd_ctrl_byte_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags the cycle
// in which the count reaches TIMEOUT-1. A clear in the same cycle wins.
module byte_timer #(
   parameter int TIMEOUT = 52080
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          at_term_s;

   assign at_term_s = (cnt_q == CW'(TIMEOUT - 1));
   assign expire    = en & ~clr & at_term_s;

   // Next count: clear has priority, wrap on expiry so the counter never overflows.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (at_term_s) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses HEADER/CMD/LEN/payload frames from a UART byte stream, feeds the
// SDRAM write FIFO and triggers one SDRAM burst per accepted frame.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] HEADER  = HEADER_DEF,
   parameter logic [7:0] CMD_WR  = CMD_WR_DEF,
   parameter logic [7:0] CMD_RD  = CMD_RD_DEF,
   parameter int         TIMEOUT = TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       sdram_done,
   output logic       wfifo_wr_en,
   output logic [7:0] wfifo_wr_data,
   output logic       wr_trig,
   output logic       rd_trig,
   output logic [7:0] burst_len,
   output logic       busy,
   output logic       err
);

   logic [2:0] state_q, state_d;
   logic       is_wr_q, is_wr_d;
   logic [7:0] len_q, len_d;
   logic [7:0] pay_cnt_q, pay_cnt_d;
   logic       wen_q, wen_d;
   logic [7:0] wdata_q, wdata_d;
   logic       wr_trig_q, wr_trig_d;
   logic       rd_trig_q, rd_trig_d;
   logic       busy_q, busy_d;
   logic       err_q, err_d;
   logic       timed_s;
   logic       expire_s;
   logic [7:0] pay_inc_s;

   assign timed_s   = (state_q == ST_CMD) || (state_q == ST_LEN) || (state_q == ST_DATA);
   assign pay_inc_s = pay_cnt_q + 8'd1;

   byte_timer #(.TIMEOUT(TIMEOUT)) u_byte_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (rx_valid | ~timed_s),
      .en     (timed_s),
      .expire (expire_s)
   );

   // Frame FSM and next values of all registered outputs.
   always_comb begin
      state_d   = state_q;
      is_wr_d   = is_wr_q;
      len_d     = len_q;
      pay_cnt_d = pay_cnt_q;
      wen_d     = 1'b0;
      wdata_d   = wdata_q;
      wr_trig_d = 1'b0;
      rd_trig_d = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pay_cnt_d = 8'd0;
            if (rx_valid && (rx_data == HEADER)) begin
               state_d = ST_CMD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (rx_valid) begin
               if (rx_data == CMD_WR) begin
                  is_wr_d = 1'b1;
                  state_d = ST_LEN;
               end else if (rx_data == CMD_RD) begin
                  is_wr_d = 1'b0;
                  state_d = ST_LEN;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (expire_s) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CMD;
            end
         end
         ST_LEN: begin
            if (rx_valid) begin
               if (rx_data != 8'd0) begin
                  len_d     = rx_data;
                  pay_cnt_d = 8'd0;
                  state_d   = is_wr_q ? ST_DATA : ST_ISSUE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (expire_s) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LEN;
            end
         end
         ST_DATA: begin
            // Bytes equal to HEADER are payload here; there is no resync.
            if (rx_valid) begin
               wen_d     = 1'b1;
               wdata_d   = rx_data;
               pay_cnt_d = pay_inc_s;
               if (pay_inc_s == len_q) begin
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_DATA;
               end
            end else if (expire_s) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_ISSUE: begin
            wr_trig_d = is_wr_q;
            rd_trig_d = ~is_wr_q;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            err_d = rx_valid;
            if (sdram_done) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         is_wr_q   <= 1'b0;
         len_q     <= 8'd0;
         pay_cnt_q <= 8'd0;
         wen_q     <= 1'b0;
         wdata_q   <= 8'd0;
         wr_trig_q <= 1'b0;
         rd_trig_q <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_wr_q   <= is_wr_d;
         len_q     <= len_d;
         pay_cnt_q <= pay_cnt_d;
         wen_q     <= wen_d;
         wdata_q   <= wdata_d;
         wr_trig_q <= wr_trig_d;
         rd_trig_q <= rd_trig_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign wfifo_wr_en   = wen_q;
   assign wfifo_wr_data = wdata_q;
   assign wr_trig       = wr_trig_q;
   assign rd_trig       = rd_trig_q;
   assign burst_len     = len_q;
   assign busy          = busy_q;
   assign err           = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl with a short timeout.
module tb_uart_cmd_ctrl;

   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       sdram_done = 1'b0;
   logic       wfifo_wr_en;
   logic [7:0] wfifo_wr_data;
   logic       wr_trig;
   logic       rd_trig;
   logic [7:0] burst_len;
   logic       busy;
   logic       err;

   int checks = 0;
   int failures = 0;

   int n_wr = 0, n_wt = 0, n_rt = 0, n_er = 0;
   logic [7:0] wq[$];
   int b_wr, b_wt, b_rt, b_er, b_q;

   always #5 clk = ~clk;

   uart_cmd_ctrl #(
      .HEADER(8'h55), .CMD_WR(8'h01), .CMD_RD(8'h02), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .sdram_done(sdram_done), .wfifo_wr_en(wfifo_wr_en),
      .wfifo_wr_data(wfifo_wr_data), .wr_trig(wr_trig), .rd_trig(rd_trig),
      .burst_len(burst_len), .busy(busy), .err(err)
   );

   // Output monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (wfifo_wr_en) begin
         n_wr <= n_wr + 1;
         wq.push_back(wfifo_wr_data);
      end
      if (wr_trig) n_wt <= n_wt + 1;
      if (rd_trig) n_rt <= n_rt + 1;
      if (err)     n_er <= n_er + 1;
   end

   task automatic snap();
      b_wr = n_wr; b_wt = n_wt; b_rt = n_rt; b_er = n_er; b_q = wq.size();
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic done_pulse();
      sdram_done = 1'b1;
      @(posedge clk); #1;
      sdram_done = 1'b0;
   endtask

   task automatic test_reset();
      #22;
      checks++;
      if ({wfifo_wr_en, wfifo_wr_data, wr_trig, rd_trig, burst_len, busy, err} !== 20'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {wfifo_wr_en, wfifo_wr_data, wr_trig, rd_trig, burst_len, busy, err});
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      snap();
      send(8'h55); send(8'h01); send(8'h03); send(8'h11);
      done_pulse();
      send(8'h22); send(8'h33);
      idle(4);
      checks++;
      if (n_wr - b_wr !== 3) begin failures++; $display("FAIL wr_count: got %0d expected 3", n_wr - b_wr); end
      checks++;
      if (wq.size() < b_q + 3 || {wq[b_q], wq[b_q+1], wq[b_q+2]} !== 24'h112233) begin
         failures++; $display("FAIL wr_data: got %0d bytes expected 11 22 33", wq.size() - b_q);
      end
      checks++;
      if (n_wt - b_wt !== 1 || n_rt - b_rt !== 0) begin
         failures++; $display("FAIL wr_trig: got wt=%0d rt=%0d expected 1/0", n_wt - b_wt, n_rt - b_rt);
      end
      checks++;
      if (burst_len !== 8'd3 || busy !== 1'b1) begin
         failures++; $display("FAIL wr_len_busy: got len=%h busy=%b expected 03/1", burst_len, busy);
      end
      done_pulse();
      checks++;
      if (busy !== 1'b0 || n_er - b_er !== 0) begin
         failures++; $display("FAIL wr_done: got busy=%b err=%0d expected 0/0", busy, n_er - b_er);
      end
   endtask

   task automatic test_read_and_wait_byte();
      snap();
      send(8'h55); send(8'h02); send(8'h10);
      idle(4);
      checks++;
      if (n_rt - b_rt !== 1 || n_wt - b_wt !== 0 || n_wr - b_wr !== 0) begin
         failures++; $display("FAIL rd_trig: got rt=%0d wt=%0d wr=%0d expected 1/0/0",
                              n_rt - b_rt, n_wt - b_wt, n_wr - b_wr);
      end
      checks++;
      if (burst_len !== 8'h10 || busy !== 1'b1) begin
         failures++; $display("FAIL rd_len_busy: got len=%h busy=%b expected 10/1", burst_len, busy);
      end
      send(8'h77);
      idle(1);
      checks++;
      if (n_er - b_er !== 1 || busy !== 1'b1 || n_wr - b_wr !== 0) begin
         failures++; $display("FAIL wait_byte: got err=%0d busy=%b wr=%0d expected 1/1/0",
                              n_er - b_er, busy, n_wr - b_wr);
      end
      done_pulse();
      checks++;
      if (busy !== 1'b0 || n_rt - b_rt !== 1) begin
         failures++; $display("FAIL rd_done: got busy=%b rt=%0d expected 0/1", busy, n_rt - b_rt);
      end
   endtask

   task automatic test_bad_frames();
      snap();
      send(8'h55); send(8'h07);
      idle(2);
      checks++;
      if (n_er - b_er !== 1 || busy !== 1'b0) begin
         failures++; $display("FAIL bad_cmd: got err=%0d busy=%b expected 1/0", n_er - b_er, busy);
      end
      send(8'h55); send(8'h01); send(8'h00);
      idle(2);
      checks++;
      if (n_er - b_er !== 2 || busy !== 1'b0 || n_wt - b_wt !== 0 || n_rt - b_rt !== 0) begin
         failures++; $display("FAIL zero_len: got err=%0d busy=%b wt=%0d rt=%0d expected 2/0/0/0",
                              n_er - b_er, busy, n_wt - b_wt, n_rt - b_rt);
      end
   endtask

   task automatic test_timeout();
      snap();
      send(8'h55); send(8'h01); send(8'h04); send(8'hAA);
      // BB lands exactly on the terminal-count cycle; the byte must win.
      idle(TO - 1);
      send(8'hBB);
      idle(1);
      checks++;
      if (n_er - b_er !== 0 || n_wr - b_wr !== 2) begin
         failures++; $display("FAIL tmo_byte_wins: got err=%0d wr=%0d expected 0/2", n_er - b_er, n_wr - b_wr);
      end
      idle(TO - 2);
      checks++;
      if (n_er - b_er !== 0 || busy !== 1'b1) begin
         failures++; $display("FAIL tmo_early: got err=%0d busy=%b expected 0/1", n_er - b_er, busy);
      end
      idle(2);
      checks++;
      if (n_er - b_er !== 1 || busy !== 1'b0 || n_wr - b_wr !== 2 || n_wt - b_wt !== 0) begin
         failures++; $display("FAIL tmo_fire: got err=%0d busy=%b wr=%0d wt=%0d expected 1/0/2/0",
                              n_er - b_er, busy, n_wr - b_wr, n_wt - b_wt);
      end
      send(8'h55); send(8'h02); send(8'h01);
      idle(3);
      checks++;
      if (n_rt - b_rt !== 1 || burst_len !== 8'h01 || n_er - b_er !== 1) begin
         failures++; $display("FAIL tmo_recover: got rt=%0d len=%h err=%0d expected 1/01/1",
                              n_rt - b_rt, burst_len, n_er - b_er);
      end
      done_pulse();
   endtask

   task automatic test_header_as_data();
      snap();
      send(8'h55); send(8'h01); send(8'h02); send(8'h55); send(8'h66);
      idle(3);
      checks++;
      if (n_wr - b_wr !== 2 || wq.size() < b_q + 2 || {wq[b_q], wq[b_q+1]} !== 16'h5566 || n_wt - b_wt !== 1) begin
         failures++; $display("FAIL hdr_as_data: got wr=%0d wt=%0d expected 2 writes 55 66 and 1 trig",
                              n_wr - b_wr, n_wt - b_wt);
      end
      done_pulse();
   endtask

   task automatic test_garbage();
      snap();
      send(8'h00); send(8'hFF); send(8'h55); send(8'h02); send(8'h01);
      idle(3);
      checks++;
      if (n_rt - b_rt !== 1 || n_er - b_er !== 0 || burst_len !== 8'h01) begin
         failures++; $display("FAIL garbage: got rt=%0d err=%0d len=%h expected 1/0/01",
                              n_rt - b_rt, n_er - b_er, burst_len);
      end
      done_pulse();
   endtask

   task automatic test_reset_mid();
      send(8'h55); send(8'h01); send(8'h04); send(8'hAA);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({wfifo_wr_en, wfifo_wr_data, wr_trig, rd_trig, burst_len, busy, err} !== 20'd0) begin
         failures++;
         $display("FAIL reset_mid: got %h expected 0",
                  {wfifo_wr_en, wfifo_wr_data, wr_trig, rd_trig, burst_len, busy, err});
      end
      @(negedge clk); rst_n = 1'b1;
      snap();
      send(8'h55); send(8'h02); send(8'h01);
      idle(3);
      checks++;
      if (n_rt - b_rt !== 1 || burst_len !== 8'h01 || n_wr - b_wr !== 0) begin
         failures++; $display("FAIL post_reset: got rt=%0d len=%h wr=%0d expected 1/01/0",
                              n_rt - b_rt, burst_len, n_wr - b_wr);
      end
      done_pulse();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_and_wait_byte();
      test_bad_frames();
      test_timeout();
      test_header_as_data();
      test_garbage();
      test_reset_mid();
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
